// File: rtl/cphy_tx_sequencer.sv
// C-PHY HS-burst sequencer: frames mapper symbols with preamble, sync and post, one symbol per clk.
// Optional periodic sync re-insertion is enabled by defining TX_PERIODIC_SYNC_EN.
module cphy_tx_sequencer #(
  parameter int unsigned PREAMBLE_LEN  = 21,
  parameter int unsigned POST_LEN      = 7,
  parameter int unsigned SYNC_INTERVAL = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        TxReqHS,
  input  logic [15:0] TxWordData,
  input  logic        TxWordValid,
  output logic        TxWordReady,
  output logic [15:0] MapData,
  input  logic [6:0]  MapRotation,
  input  logic [6:0]  MapPolarity,
  input  logic [6:0]  MapFlip,
  output logic [2:0]  TxSymbol,
  output logic        TxSymbolValid,
  output logic        TxActive
);

  typedef enum logic [2:0] {StIdle, StPreamble, StSync, StData, StPost} state_e;

  localparam logic [7:0] PreLast  = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] PostLast = 8'(POST_LEN - 1);
  localparam logic [2:0] SymPre   = 3'b011;
  localparam logic [2:0] SymPost  = 3'b100;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [20:0] sym_q, sym_d;
  logic [2:0]  tx_sym_q, tx_sym_d;
  logic        tx_vld_q, tx_vld_d;
  logic [20:0] map_sym;
  logic        ready_window, accept, resync;

  assign MapData = TxWordData;

  always_comb begin
    map_sym = '0;
    for (int i = 0; i < 7; i++) begin
      map_sym[3*i +: 3] = {MapFlip[i], MapRotation[i], MapPolarity[i]};
    end
  end

  assign ready_window = ((state_q == StSync) && (cnt_q == 8'd6)) ||
                        ((state_q == StData) && (cnt_q == 8'd0));
  assign TxWordReady  = TxReqHS & ready_window & ~resync;
  assign accept       = TxWordReady & TxWordValid;

`ifdef TX_PERIODIC_SYNC_EN
  // Words accepted since the last sync; the first word after a sync counts as 1.
  logic [7:0] wcnt_q, wcnt_d;

  assign resync = (state_q == StData) && (cnt_q == 8'd0) && (wcnt_q == 8'(SYNC_INTERVAL));

  always_comb begin
    wcnt_d = wcnt_q;
    if (accept) begin
      wcnt_d = (state_q == StSync) ? 8'd1 : wcnt_q + 8'd1;
    end else if (resync) begin
      wcnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wcnt_q <= 8'd0;
    else        wcnt_q <= wcnt_d;
  end
`else
  assign resync = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sym_d   = accept ? map_sym : sym_q;
    case (state_q)
      StIdle: begin
        if (TxReqHS) begin
          state_d = StPreamble;
          cnt_d   = 8'd0;
        end
      end
      StPreamble: begin
        if (cnt_q == PreLast) begin
          state_d = StSync;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StSync: begin
        if (cnt_q == 8'd6) begin
          state_d = accept ? StData : StPost;
          cnt_d   = accept ? 8'd6 : 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StData: begin
        // Data index counts down so sym[6] leaves first.
        if (cnt_q == 8'd0) begin
          if (accept) begin
            cnt_d = 8'd6;
          end else begin
            state_d = resync ? StSync : StPost;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StPost: begin
        if (cnt_q == PostLast) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Symbol output is decoded from next state so it is registered alongside the state.
  always_comb begin
    tx_sym_d = 3'b000;
    tx_vld_d = 1'b1;
    case (state_d)
      StPreamble: tx_sym_d = SymPre;
      StSync:     tx_sym_d = ((cnt_d == 8'd0) || (cnt_d == 8'd6)) ? SymPre : SymPost;
      StData:     tx_sym_d = sym_d[3*cnt_d[2:0] +: 3];
      StPost:     tx_sym_d = SymPost;
      default:    tx_vld_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      sym_q    <= '0;
      tx_sym_q <= 3'b000;
      tx_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sym_q    <= sym_d;
      tx_sym_q <= tx_sym_d;
      tx_vld_q <= tx_vld_d;
    end
  end

  assign TxSymbol      = tx_sym_q;
  assign TxSymbolValid = tx_vld_q;
  assign TxActive      = tx_vld_q;

endmodule

// File: tb/tb_cphy_tx_sequencer.sv
// Directed bench for cphy_tx_sequencer: expected symbol stream is queued as stimulus is planned
// and popped for every valid symbol the DUT emits.
module tb_cphy_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        TxReqHS;
  logic [15:0] TxWordData;
  logic        TxWordValid;
  logic        TxWordReady;
  logic [15:0] MapData;
  logic [6:0]  MapRotation;
  logic [6:0]  MapPolarity;
  logic [6:0]  MapFlip;
  logic [2:0]  TxSymbol;
  logic        TxSymbolValid;
  logic        TxActive;

  logic [2:0]  exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          act_cnt, ready_cnt, acc_cnt;
  bit          acc_flag;
  logic [20:0] map_s;

  always #5 clk = ~clk;

  cphy_tx_sequencer #(
    .PREAMBLE_LEN (21),
    .POST_LEN     (7),
    .SYNC_INTERVAL(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .TxReqHS      (TxReqHS),
    .TxWordData   (TxWordData),
    .TxWordValid  (TxWordValid),
    .TxWordReady  (TxWordReady),
    .MapData      (MapData),
    .MapRotation  (MapRotation),
    .MapPolarity  (MapPolarity),
    .MapFlip      (MapFlip),
    .TxSymbol     (TxSymbol),
    .TxSymbolValid(TxSymbolValid),
    .TxActive     (TxActive)
  );

  // Mapper stand-in; the two named words carry the symbol sets from the reference examples.
  function automatic logic [20:0] map_model(input logic [15:0] w);
    logic [20:0] s;
    s = '0;
    case (w)
      16'h000F: s = {3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 3'b011};
      16'h6025: s = {3'b000, 3'b000, 3'b000, 3'b010, 3'b100, 3'b001, 3'b001};
      default: begin
        for (int i = 0; i < 7; i++) s[3*i +: 3] = {w[i] ^ w[15], w[i+7], w[i+9]};
      end
    endcase
    return s;
  endfunction

  always_comb begin
    MapFlip     = '0;
    MapRotation = '0;
    MapPolarity = '0;
    map_s       = map_model(MapData);
    for (int i = 0; i < 7; i++) begin
      MapFlip[i]     = map_s[3*i+2];
      MapRotation[i] = map_s[3*i+1];
      MapPolarity[i] = map_s[3*i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_preamble_sync();
    for (int i = 0; i < 21; i++) exp_q.push_back(3'b011);
    push_sync();
  endtask

  task automatic push_sync();
    exp_q.push_back(3'b011);
    for (int i = 0; i < 5; i++) exp_q.push_back(3'b100);
    exp_q.push_back(3'b011);
  endtask

  task automatic push_word(input logic [15:0] w);
    logic [20:0] s;
    s = map_model(w);
    for (int i = 6; i >= 0; i--) exp_q.push_back(s[3*i +: 3]);
  endtask

  task automatic push_post();
    for (int i = 0; i < 7; i++) exp_q.push_back(3'b100);
  endtask

  task automatic clear_counts();
    act_cnt   = 0;
    ready_cnt = 0;
    acc_cnt   = 0;
  endtask

  // Samples 4 ns after the previous edge, then advances 1 ns past the next rising edge.
  task automatic tick();
    logic [2:0] e;
    #3;
    if (TxActive === 1'b1) act_cnt++;
    if (TxWordReady === 1'b1) ready_cnt++;
    acc_flag = (TxWordReady === 1'b1) && (TxWordValid === 1'b1);
    if (acc_flag) acc_cnt++;
    if (TxSymbolValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sym_extra", 32'(TxSymbolValid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sym", 32'(TxSymbol), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (acc_flag) begin
        got = 1'b1;
        break;
      end
    end
    check("accept_seen", 32'(got), 32'd1);
  endtask

  task automatic wait_end();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if ((TxActive === 1'b0) && (exp_q.size() == 0)) begin
        done = 1'b1;
        break;
      end
    end
    check("burst_end", 32'(done), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a request pending.
    clear_counts();
    rst_n       = 1'b0;
    TxReqHS     = 1'b1;
    TxWordValid = 1'b1;
    TxWordData  = 16'h000F;
    repeat (3) tick();
    check("rst_symbol", 32'(TxSymbol), 32'd0);
    check("rst_valid", 32'(TxSymbolValid), 32'd0);
    check("rst_active", 32'(TxActive), 32'd0);
    check("rst_ready", 32'(TxWordReady), 32'd0);

    // Single word.
    clear_counts();
    push_preamble_sync();
    push_word(16'h000F);
    push_post();
    rst_n = 1'b1;
    tick();
    check("first_sym_latency", 32'(TxSymbolValid), 32'd1);
    wait_accept();
    TxReqHS     = 1'b0;
    TxWordValid = 1'b0;
    wait_end();
    check("single_active_cycles", 32'(act_cnt), 32'd42);
    check("single_ready_cycles", 32'(ready_cnt), 32'd1);
    check("single_accepts", 32'(acc_cnt), 32'd1);
    repeat (2) tick();

    // Back-to-back words.
    clear_counts();
    push_preamble_sync();
    push_word(16'h000F);
    push_word(16'h6025);
    push_post();
    TxReqHS     = 1'b1;
    TxWordValid = 1'b1;
    TxWordData  = 16'h000F;
    wait_accept();
    TxWordData = 16'h6025;
    wait_accept();
    TxReqHS     = 1'b0;
    TxWordValid = 1'b0;
    wait_end();
    check("b2b_active_cycles", 32'(act_cnt), 32'd49);
    check("b2b_ready_cycles", 32'(ready_cnt), 32'd2);
    check("b2b_accepts", 32'(acc_cnt), 32'd2);
    repeat (2) tick();

    // Underflow at the first word's sym[0]; a late valid during post is ignored.
    clear_counts();
    push_preamble_sync();
    push_word(16'h000F);
    push_post();
    TxReqHS     = 1'b1;
    TxWordValid = 1'b1;
    TxWordData  = 16'h000F;
    wait_accept();
    TxWordValid = 1'b0;
    repeat (7) tick();
    TxWordValid = 1'b1;
    TxWordData  = 16'h6025;
    repeat (2) tick();
    TxReqHS     = 1'b0;
    TxWordValid = 1'b0;
    wait_end();
    check("uflow_active_cycles", 32'(act_cnt), 32'd42);
    check("uflow_ready_cycles", 32'(ready_cnt), 32'd2);
    check("uflow_accepts", 32'(acc_cnt), 32'd1);
    repeat (2) tick();

    // Request dropped during preamble.
    clear_counts();
    push_preamble_sync();
    push_post();
    TxReqHS     = 1'b1;
    TxWordValid = 1'b1;
    TxWordData  = 16'h1234;
    repeat (3) tick();
    TxReqHS = 1'b0;
    wait_end();
    TxWordValid = 1'b0;
    check("drop_active_cycles", 32'(act_cnt), 32'd35);
    check("drop_ready_cycles", 32'(ready_cnt), 32'd0);
    check("drop_accepts", 32'(acc_cnt), 32'd0);
    repeat (3) tick();
    check("quiet_after_drop", 32'(TxActive), 32'd0);

`ifdef TX_PERIODIC_SYNC_EN
    begin
      logic [15:0] words [5];
      words[0] = 16'hA5C3;
      words[1] = 16'h0F0F;
      words[2] = 16'h8001;
      words[3] = 16'h7E55;
      words[4] = 16'h1234;
      clear_counts();
      push_preamble_sync();
      push_word(words[0]);
      push_word(words[1]);
      push_sync();
      push_word(words[2]);
      push_word(words[3]);
      push_sync();
      push_word(words[4]);
      push_post();
      TxReqHS     = 1'b1;
      TxWordValid = 1'b1;
      TxWordData  = words[0];
      for (int k = 0; k < 5; k++) begin
        wait_accept();
        if (k < 4) TxWordData = words[k+1];
      end
      TxReqHS     = 1'b0;
      TxWordValid = 1'b0;
      wait_end();
      check("psync_active_cycles", 32'(act_cnt), 32'd84);
      check("psync_ready_cycles", 32'(ready_cnt), 32'd5);
      check("psync_accepts", 32'(acc_cnt), 32'd5);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
